// File: rtl/heroe_pkg.sv
// Shared HEROE constants: game state codes, obstacle lane segment masks and LFSR seed/taps.
package heroe_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    WLCM = 3'd1,
    CH   = 3'd2,
    PA   = 3'd5,
    GAME = 3'd6
  } estado_juego_t;

  // Segment order within a digit is {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_TOP = 7'b1000000;
  localparam logic [6:0] SEG_MID = 7'b0000001;
  localparam logic [6:0] SEG_BOT = 7'b0001000;

  // Taps x^8+x^6+x^5+x^4+1 map to register bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/obstaculos_gen_if.sv
// Game-state inputs and obstacle-field outputs of the obstacle generator; master is the generator side.
interface obstaculos_gen_if;
  logic [2:0]  presente;
  logic [1:0]  W_or_L;
  logic [20:0] display_obs;
  logic        clk_obstaculos;
  logic        paso;
  logic [1:0]  nivel;
  logic [7:0]  esquivados;

  modport master (
    input  presente, W_or_L,
    output display_obs, clk_obstaculos, paso, nivel, esquivados
  );

  modport slave (
    output presente, W_or_L,
    input  display_obs, clk_obstaculos, paso, nivel, esquivados
  );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, one shift per clk, no enable and no stall; async reset to the seed.
module lfsr8
  import heroe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= LFSR_SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/obstaculos_gen.sv
// Obstacle spawner/scroller: field shifts one digit every P=PASO_CICLOS>>nivel cycles; holds on pause or loss.
// Outputs registered, no backpressure. Define OBS_DOBLE_EN to spawn top+bottom obstacles at levels 2-3.
module obstaculos_gen
  import heroe_pkg::*;
#(
  parameter int PASO_CICLOS   = 25_000_000,
  parameter int ANCHO_PRESC   = 25,
  parameter int OBS_POR_NIVEL = 8,
  parameter int MIN_GAP       = 1
) (
  input logic              clk,
  input logic              rst_n,
  obstaculos_gen_if.master bus
);

  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam int CNT_W = $clog2(OBS_POR_NIVEL + 1);
  localparam logic [31:0]      PASO_U     = 32'(PASO_CICLOS);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(OBS_POR_NIVEL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSA, FREEZE} fase_t;

  fase_t                  fase;
  logic [ANCHO_PRESC-1:0] presc, presc_inc;
  logic [1:0]             nivel, nivel_nx;
  logic [GAP_W-1:0]       gap, gap_nx;
  logic [CNT_W-1:0]       cnt_niv, cnt_niv_nx, cnt_inc;
  logic [7:0]             esq, esq_nx;
  logic [20:0]            campo;
  logic                   clk_obs, paso_q;
  logic [6:0]             spawn_mask;
  logic [31:0]            per_len, per_half;
  logic                   wrap, pres_game, pres_pa, perdio, esquiva;
  logic [1:0]             carril;
  logic [5:0]             lfsr_unused;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     ({lfsr_unused, carril})
  );

  always_comb begin
    pres_game = (bus.presente == GAME);
    pres_pa   = (bus.presente == PA);
    perdio    = (bus.W_or_L == 2'b01);

    // nivel only moves at a wrap, so it already acts as the period latched at the last wrap.
    per_len   = PASO_U >> nivel;
    per_half  = per_len >> 1;
    presc_inc = presc + ANCHO_PRESC'(1);
    wrap      = (32'(presc) == per_len - 32'd1);

    spawn_mask = '0;
    if (gap == '0) begin
      case (carril)
        2'b00:   spawn_mask = SEG_TOP;
        2'b01:   spawn_mask = SEG_MID;
        2'b10:   spawn_mask = SEG_BOT;
        default: begin
`ifdef OBS_DOBLE_EN
          if (nivel >= 2'd2) spawn_mask = SEG_TOP | SEG_BOT;
`else
          spawn_mask = '0;
`endif
        end
      endcase
    end

    if (spawn_mask != '0) gap_nx = GAP_RELOAD;
    else if (gap != '0)   gap_nx = gap - GAP_W'(1);
    else                  gap_nx = gap;

    // An obstacle leaving the hero digit without a collision counts as dodged.
    esquiva    = (campo[6:0] != '0) && (bus.W_or_L == 2'b00);
    esq_nx     = (esquiva && esq != 8'hFF) ? esq + 8'd1 : esq;
    cnt_inc    = cnt_niv + CNT_W'(1);
    cnt_niv_nx = cnt_niv;
    nivel_nx   = nivel;
    if (esquiva) begin
      if (cnt_inc == CNT_TOP) begin
        cnt_niv_nx = '0;
        if (nivel != 2'd3) nivel_nx = nivel + 2'd1;
      end else begin
        cnt_niv_nx = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase    <= IDLE;
      presc   <= '0;
      nivel   <= '0;
      gap     <= '0;
      cnt_niv <= '0;
      esq     <= '0;
      campo   <= '0;
      clk_obs <= 1'b0;
      paso_q  <= 1'b0;
    end else begin
      paso_q <= 1'b0;
      if (!(pres_game || pres_pa) || fase == IDLE) begin
        presc   <= '0;
        nivel   <= '0;
        gap     <= '0;
        cnt_niv <= '0;
        esq     <= '0;
        campo   <= '0;
        clk_obs <= 1'b0;
        fase    <= (pres_game && !perdio) ? RUN : IDLE;
      end else begin
        case (fase)
          RUN: begin
            // A loss seen on a wrap cycle freezes the field before it can shift.
            if (perdio) begin
              fase <= FREEZE;
            end else if (pres_pa) begin
              fase <= PAUSA;
            end else if (wrap) begin
              presc   <= '0;
              paso_q  <= 1'b1;
              clk_obs <= 1'b1;
              campo   <= {spawn_mask, campo[20:7]};
              gap     <= gap_nx;
              esq     <= esq_nx;
              cnt_niv <= cnt_niv_nx;
              nivel   <= nivel_nx;
            end else begin
              presc <= presc_inc;
              if (32'(presc_inc) == per_half) clk_obs <= 1'b0;
            end
          end
          PAUSA: if (pres_game) fase <= RUN;
          default: ;
        endcase
      end
    end
  end

  assign bus.display_obs    = campo;
  assign bus.clk_obstaculos = clk_obs;
  assign bus.paso           = paso_q;
  assign bus.nivel          = nivel;
  assign bus.esquivados     = esq;

endmodule

// File: doc/obstaculos_gen.md
# obstaculos_gen

Obstacle generator and scroller for the HEROE game. It produces the three-digit 7-segment obstacle field `display_obs[20:0]` and the step clock `clk_obstaculos` consumed by the collision stage. Obstacles are spawned pseudo-randomly into the leftmost digit and scroll one digit per step toward the hero digit, bits 6:0. Step rate rises with the count of dodged obstacles. The block runs only while the game state machine is in GAME, and it freezes the field on a loss.

## Interface
- `PASO_CICLOS`, default 25_000_000: clk cycles per step at level 0. Must be even and ≥ 16.
- `ANCHO_PRESC`, default 25: prescaler width. Must hold `PASO_CICLOS-1`.
- `OBS_POR_NIVEL`, default 8: dodged obstacles needed per level increment.
- `MIN_GAP`, default 1: minimum number of empty digits forced after each spawn.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `presente` in 3: game state code, OFF=0, WLCM=1, CH=2, PA=5, GAME=6. WL shares code 6 with GAME.
- `W_or_L` in 2: collision result. `2'b01` means the player lost.
- `display_obs` out 21: obstacle segments. Bits [20:14] are digit 2 (entry), [13:7] are digit 1, [6:0] are digit 0 (hero digit). Within each digit, bit 6 is segment a and bit 0 is segment g.
- `clk_obstaculos` out 1: step clock. High for the first half of each step period.
- `paso` out 1: one-cycle strobe, asserted in the cycle the field shifts.
- `nivel` out 2: speed level, 0..3.
- `esquivados` out 8: dodged-obstacle count, saturates at 255.

## Operation
- Reset values:
  - `display_obs`=0, `clk_obstaculos`=0, `paso`=0, `nivel`=0, `esquivados`=0.
  - State is IDLE, prescaler=0, gap counter=0, per-level counter=0.
  - LFSR = 8'hA5.
- States and transitions:
  - IDLE → RUN when `presente`==GAME and `W_or_L`!=01.
  - RUN → PAUSA when `presente`==PA. PAUSA → RUN when `presente`==GAME.
  - RUN → FREEZE when `W_or_L`==01.
  - Any state → IDLE when `presente` ∉ {GAME, PA}.
- IDLE:
  - Clears `display_obs`, prescaler, `esquivados`, `nivel`, gap counter and per-level counter.
  - Holds `clk_obstaculos` at 0.
  - LFSR keeps stepping every cycle in all states, so each game differs.
- PAUSA and FREEZE: every register is held except the LFSR, including `clk_obstaculos`. No extra edges are generated.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every clk.
- Step in RUN, taken when the prescaler wraps to 0:
  - Shift: `display_obs` ← {spawn_mask, `display_obs`[20:14], `display_obs`[13:7]}.
  - Spawn when the gap counter is 0. Lane comes from `lfsr[1:0]`: 00 → 7'b1000000 (top), 01 → 7'b0000001 (middle), 10 → 7'b0001000 (bottom), 11 → no spawn.
  - A spawn reloads the gap counter to `MIN_GAP`. A non-spawn step decrements it, saturating at 0.
  - Dodge: if the outgoing `display_obs`[6:0] is nonzero and `W_or_L`==00, `esquivados` increments (saturating) and the per-level counter increments.
  - When the per-level counter reaches `OBS_POR_NIVEL`, it resets to 0 and `nivel` increments, saturating at 3.

## Timing
- Step period P = `PASO_CICLOS` >> `nivel`. P is latched at each wrap, so a level change takes effect from the next period.
- The prescaler counts 0..P-1. The first shift occurs P cycles after entering RUN.
- `clk_obstaculos` is registered as 1 while prescaler < P/2. Its rising edge coincides with the `display_obs` update and with `paso`.
- The collision stage samples on the negedge of `clk_obstaculos`. Data is therefore stable P/2 cycles before sampling.
- `W_or_L`==01 arriving in the same cycle as a wrap: the FREEZE transition wins and no shift occurs.
- Reset mid-game: all outputs return to their reset values immediately, asynchronously.

## Configuration
- `OBS_DOBLE_EN` defined: when `lfsr[1:0]`==11 and `nivel` ≥ 2, a double obstacle 7'b1001000 (top and bottom) is spawned.
- `OBS_DOBLE_EN` undefined: code 11 never spawns.

## Structure
- Package `heroe_pkg`:
  - State codes OFF/WLCM/CH/PA/GAME.
  - Lane masks SEG_TOP, SEG_MID, SEG_BOT.
  - LFSR seed 8'hA5 and tap mask.
- Sub-module `lfsr8`: enable-free 8-bit LFSR with async reset to the seed, output `q[7:0]`.

## Test plan
Benches override `PASO_CICLOS`=16 and `OBS_POR_NIVEL`=2.
- Reset, then hold `presente`=GAME with `W_or_L`=00 → first `paso` at cycle 16, `clk_obstaculos` high for cycles 16..23, the spawn mask appears in bits [20:14], and it reaches [6:0] after two more steps.
- Force the LFSR state so `lfsr[1:0]`=00 → `display_obs`=21'h100000 after the step. Two steps later the field is 21'h000040, and the next step increments `esquivados` to 1.
- Dodge 2 obstacles → `nivel`=1 and P becomes 8 from the following period. After 6 dodges `nivel`=3 and stays saturated through an 8th dodge.
- Assert `W_or_L`=01 in the same cycle as a prescaler wrap → no shift, `display_obs` and `clk_obstaculos` are frozen. `presente`=OFF then gives all zeros.
- `presente`=PA for 40 cycles mid-period → prescaler and outputs are held, and resuming GAME completes the remaining cycles of the period exactly.
- Assert `rst_n` low mid-step → all outputs are 0 in the same cycle, with no dependency on `clk`.
